// File: rtl/parking_pkg.sv
// parking_pkg: shared types and defaults for the parking gate controller.
//   lane_state_e       : lane FSM states (IDLE, CHECK, OPEN, DENY, CLOSE)
//   OPEN_TIMEOUT_DEF   : default cycles a barrier waits open for the pass sensor
//   CLOSE_HOLD_DEF     : default cycles a barrier stays closed before re-arming
//   DENY_CNT_W         : width of the optional denied-entry counter
//   max_int()          : helper used to size the lane timer
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    DENY  = 3'd3,
    CLOSE = 3'd4
  } lane_state_e;

  localparam int OPEN_TIMEOUT_DEF = 16;
  localparam int CLOSE_HOLD_DEF   = 4;
  localparam int DENY_CNT_W       = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_lane.sv
// parking_gate_lane: one barrier lane (FSM + shared timer).
// Parameters:
//   OPEN_TIMEOUT : cycles the barrier stays open waiting for pass (>= 2)
//   CLOSE_HOLD   : minimum closed cycles before re-arming (>= 1)
//   HAS_CHECK    : 1 = go through CHECK (vacancy test, may DENY); 0 = IDLE -> OPEN
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   arrive       : car present at the loop
//   is_uni       : car type, latched when the arrival is accepted in IDLE
//   pass         : car crossed the barrier (honoured only in OPEN)
//   vacancy      : space available for the latched type (sampled only in CHECK)
//   state        : current FSM state (debug visibility)
//   gate_open    : barrier open command (registered)
//   denied       : high while in DENY (registered)
//   timeout      : one-cycle pulse when OPEN expires without pass
//   strobe       : one-cycle car-counted pulse, the cycle after pass is sampled
//   uni_q        : latched car type, valid during the strobe cycle
// Strobe semantics: strobe is a single-cycle valid with no ready; the counter
// must consume it in that cycle. At most one strobe per car: a lane re-arms
// only through IDLE, which needs arrive to have dropped.
module parking_gate_lane
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_HOLD   = CLOSE_HOLD_DEF,
  parameter bit HAS_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arrive,
  input  logic        is_uni,
  input  logic        pass,
  input  logic        vacancy,
  output lane_state_e state,
  output logic        gate_open,
  output logic        denied,
  output logic        timeout,
  output logic        strobe,
  output logic        uni_q
);

  localparam int TW = $clog2(max_int(OPEN_TIMEOUT, CLOSE_HOLD) + 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(CLOSE_HOLD - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      uni_q     <= 1'b0;
      gate_open <= 1'b0;
      denied    <= 1'b0;
      timeout   <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      // Pulse outputs default low; they are set only on the transition edge.
      strobe  <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (arrive) begin
            uni_q <= is_uni;
            if (HAS_CHECK) begin
              state <= CHECK;
            end else begin
              state     <= OPEN;
              gate_open <= 1'b1;
            end
          end
        end
        CHECK: begin
          timer <= '0;
          if (vacancy) begin
            state     <= OPEN;
            gate_open <= 1'b1;
          end else begin
            state  <= DENY;
            denied <= 1'b1;
          end
        end
        OPEN: begin
          // Pass takes priority over an expiry on the same cycle.
          if (pass) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
            strobe    <= 1'b1;
            timer     <= '0;
          end else if (timer == OPEN_LAST) begin
            state     <= CLOSE;
            gate_open <= 1'b0;
            timeout   <= 1'b1;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DENY: begin
          timer <= '0;
          if (!arrive) begin
            state  <= IDLE;
            denied <= 1'b0;
          end
        end
        CLOSE: begin
          // Timer saturates at HOLD_LAST while the car is still on the loop.
          if (timer == HOLD_LAST) begin
            if (!arrive) begin
              state <= IDLE;
              timer <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          gate_open <= 1'b0;
          denied    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier controller feeding the occupancy counter.
// Optional feature macro: PARKING_GATE_DENY_COUNT_EN adds denied_count, a
// saturating count of CHECK->DENY transitions on the entry lane.
// Parameters: OPEN_TIMEOUT (>= 2), CLOSE_HOLD (>= 1).
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   entry_arrive/is_uni/pass           : entry loop, badge type, pass sensor
//   exit_arrive/is_uni/pass            : exit loop, car type, pass sensor
//   uni_is_vacated_space               : counter flag, university space free
//   is_vacated_space                   : counter flag, public space free
//   entry_gate_open, exit_gate_open    : barrier commands
//   entry_denied                       : entry refused (no space for type)
//   entry_timeout, exit_timeout        : one-cycle abort pulses
//   car_entered / is_uni_car_entered   : one-cycle strobe + type to counter
//   car_exited  / is_uni_car_exited    : one-cycle strobe + type to counter
//   denied_count (macro only)          : saturating denied-entry count
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_HOLD   = CLOSE_HOLD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_arrive,
  input  logic entry_is_uni,
  input  logic entry_pass,
  input  logic exit_arrive,
  input  logic exit_is_uni,
  input  logic exit_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic entry_timeout,
  output logic exit_timeout,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited
`ifdef PARKING_GATE_DENY_COUNT_EN
  ,
  output logic [DENY_CNT_W-1:0] denied_count
`endif
);

  lane_state_e entry_state;
  lane_state_e exit_state;
  logic        entry_uni_q;
  logic        entry_vac;
  logic        exit_denied;

  // Vacancy for the entry car is chosen by its latched type; the lane only
  // looks at it while in CHECK.
  assign entry_vac = entry_uni_q ? uni_is_vacated_space : is_vacated_space;

  parking_gate_lane #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CLOSE_HOLD   (CLOSE_HOLD),
    .HAS_CHECK    (1'b1)
  ) u_entry (
    .clk       (clk),
    .reset     (reset),
    .arrive    (entry_arrive),
    .is_uni    (entry_is_uni),
    .pass      (entry_pass),
    .vacancy   (entry_vac),
    .state     (entry_state),
    .gate_open (entry_gate_open),
    .denied    (entry_denied),
    .timeout   (entry_timeout),
    .strobe    (car_entered),
    .uni_q     (entry_uni_q)
  );

  assign is_uni_car_entered = entry_uni_q;

  // Exits never need a vacancy check.
  parking_gate_lane #(
    .OPEN_TIMEOUT (OPEN_TIMEOUT),
    .CLOSE_HOLD   (CLOSE_HOLD),
    .HAS_CHECK    (1'b0)
  ) u_exit (
    .clk       (clk),
    .reset     (reset),
    .arrive    (exit_arrive),
    .is_uni    (exit_is_uni),
    .pass      (exit_pass),
    .vacancy   (1'b1),
    .state     (exit_state),
    .gate_open (exit_gate_open),
    .denied    (exit_denied),
    .timeout   (exit_timeout),
    .strobe    (car_exited),
    .uni_q     (is_uni_car_exited)
  );

`ifdef PARKING_GATE_DENY_COUNT_EN
  // CHECK with no vacancy is exactly the CHECK->DENY transition edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      denied_count <= '0;
    end else if (entry_state == CHECK && !entry_vac && denied_count != '1) begin
      denied_count <= denied_count + 1'b1;
    end
  end
`endif

  // Exit lane never denies; lane states are kept for debug visibility.
  logic unused_sigs;
  assign unused_sigs = ^{exit_denied, exit_state, entry_state};

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed bench for parking_gate_ctrl with a strobe
// scoreboard (expected car types queued when pass is driven, popped when the
// DUT strobes).
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic entry_arrive = 0, entry_is_uni = 0, entry_pass = 0;
  logic exit_arrive = 0, exit_is_uni = 0, exit_pass = 0;
  logic uni_is_vacated_space = 0, is_vacated_space = 0;
  logic entry_gate_open, exit_gate_open, entry_denied;
  logic entry_timeout, exit_timeout;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
`ifdef PARKING_GATE_DENY_COUNT_EN
  logic [DENY_CNT_W-1:0] denied_count;
`endif

  parking_gate_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .entry_arrive         (entry_arrive),
    .entry_is_uni         (entry_is_uni),
    .entry_pass           (entry_pass),
    .exit_arrive          (exit_arrive),
    .exit_is_uni          (exit_is_uni),
    .exit_pass            (exit_pass),
    .uni_is_vacated_space (uni_is_vacated_space),
    .is_vacated_space     (is_vacated_space),
    .entry_gate_open      (entry_gate_open),
    .exit_gate_open       (exit_gate_open),
    .entry_denied         (entry_denied),
    .entry_timeout        (entry_timeout),
    .exit_timeout         (exit_timeout),
    .car_entered          (car_entered),
    .is_uni_car_entered   (is_uni_car_entered),
    .car_exited           (car_exited),
    .is_uni_car_exited    (is_uni_car_exited)
`ifdef PARKING_GATE_DENY_COUNT_EN
    ,
    .denied_count         (denied_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [0:0] exp_ent_q[$];
  logic [0:0] exp_ext_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobes are compared against the queued car types at the falling edge.
  always @(negedge clk) begin
    if (car_entered) begin
      if (exp_ent_q.size() == 0) chk("car_entered_unexpected", car_entered, 0);
      else chk("is_uni_car_entered", is_uni_car_entered, exp_ent_q.pop_front());
    end
    if (car_exited) begin
      if (exp_ext_q.size() == 0) chk("car_exited_unexpected", car_exited, 0);
      else chk("is_uni_car_exited", is_uni_car_exited, exp_ext_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_entry_gate_open"}, entry_gate_open, 0);
    chk({tag, "_exit_gate_open"}, exit_gate_open, 0);
    chk({tag, "_entry_denied"}, entry_denied, 0);
    chk({tag, "_timeouts"}, {entry_timeout, exit_timeout}, 0);
    chk({tag, "_strobes"}, {car_entered, car_exited}, 0);
    chk({tag, "_types"}, {is_uni_car_entered, is_uni_car_exited}, 0);
`ifdef PARKING_GATE_DENY_COUNT_EN
    chk({tag, "_denied_count"}, denied_count, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset, all inputs low
    tick(3);
    chk_all_zero("in_reset");
    reset = 1'b1;
    tick();
    chk_all_zero("after_reset");
    chk("entry_state_idle", 32'(dut.u_entry.state), 32'(IDLE));

    // Admitted university entry
    uni_is_vacated_space = 1; is_vacated_space = 1;
    entry_arrive = 1; entry_is_uni = 1;
    tick();
    chk("entry_check_gate_closed", entry_gate_open, 0);
    chk("entry_state_check", 32'(dut.u_entry.state), 32'(CHECK));
    entry_is_uni = 0;                 // type was latched at arrival
    tick();
    chk("entry_gate_open", entry_gate_open, 1);
    uni_is_vacated_space = 0;         // must not revoke an admitted car
    tick(2);
    chk("entry_still_open", entry_gate_open, 1);
    entry_pass = 1;
    exp_ent_q.push_back(1'b1);
    tick();
    chk("car_entered_pulse", car_entered, 1);
    chk("entry_gate_closed", entry_gate_open, 0);
    tick();
    chk("car_entered_one_cycle", car_entered, 0);
    tick(5);                          // pass and arrive held: no re-count
    chk("entry_wait_arrive_low", 32'(dut.u_entry.state), 32'(CLOSE));
    chk("entry_held_closed", entry_gate_open, 0);
    entry_arrive = 0; entry_pass = 0;
    tick();
    chk("entry_rearmed", 32'(dut.u_entry.state), 32'(IDLE));

    // Public entry with no public space -> denied
    uni_is_vacated_space = 1; is_vacated_space = 0;
    entry_arrive = 1; entry_is_uni = 0;
    tick(2);
    chk("entry_denied_set", entry_denied, 1);
    chk("denied_gate_closed", entry_gate_open, 0);
    tick(3);
    chk("entry_denied_hold", entry_denied, 1);
`ifdef PARKING_GATE_DENY_COUNT_EN
    chk("denied_count_one", denied_count, 1);
`endif
    entry_arrive = 0;
    tick();
    chk("entry_denied_clear", entry_denied, 0);
    chk("deny_back_idle", 32'(dut.u_entry.state), 32'(IDLE));

    // Open with no pass -> timeout after 16 open cycles
    is_vacated_space = 1;
    entry_arrive = 1;
    tick(2);
    chk("to_gate_open", entry_gate_open, 1);
    tick(OPEN_TIMEOUT_DEF - 1);
    chk("to_open_last_cycle", entry_gate_open, 1);
    chk("to_no_early_timeout", entry_timeout, 0);
    tick();
    chk("to_gate_closed", entry_gate_open, 0);
    chk("entry_timeout_pulse", entry_timeout, 1);
    chk("to_no_strobe", car_entered, 0);
    tick();
    chk("entry_timeout_one_cycle", entry_timeout, 0);
    entry_arrive = 0;
    tick(CLOSE_HOLD_DEF);
    chk("to_back_idle", 32'(dut.u_entry.state), 32'(IDLE));

    // Pass on the final open cycle wins over the timeout
    entry_arrive = 1; entry_is_uni = 0;
    tick(2);
    tick(OPEN_TIMEOUT_DEF - 1);
    entry_pass = 1;
    exp_ent_q.push_back(1'b0);
    tick();
    chk("pass_wins_strobe", car_entered, 1);
    chk("pass_wins_no_timeout", entry_timeout, 0);
    entry_pass = 0; entry_arrive = 0;
    tick(CLOSE_HOLD_DEF);
    chk("pass_wins_idle", 32'(dut.u_entry.state), 32'(IDLE));

    // Exit lane: closed exactly CLOSE_HOLD cycles when arrive drops at once
    exit_arrive = 1; exit_is_uni = 0;
    tick();
    chk("exit_gate_open", exit_gate_open, 1);
    exit_pass = 1; exit_arrive = 0;
    exp_ext_q.push_back(1'b0);
    tick();
    chk("car_exited_pulse", car_exited, 1);
    exit_pass = 0;
    tick(CLOSE_HOLD_DEF - 1);
    chk("exit_hold_close", 32'(dut.u_exit.state), 32'(CLOSE));
    tick();
    chk("exit_hold_done", 32'(dut.u_exit.state), 32'(IDLE));

    // Simultaneous public entry pass and university exit pass
    entry_arrive = 1; entry_is_uni = 0;
    tick();
    exit_arrive = 1; exit_is_uni = 1;
    tick();
    chk("sim_both_open", {entry_gate_open, exit_gate_open}, 2'b11);
    entry_pass = 1; exit_pass = 1;
    exp_ent_q.push_back(1'b0);
    exp_ext_q.push_back(1'b1);
    tick();
    chk("sim_both_strobes", {car_entered, car_exited}, 2'b11);
    chk("sim_types", {is_uni_car_entered, is_uni_car_exited}, 2'b01);
    entry_pass = 0; exit_pass = 0; entry_arrive = 0; exit_arrive = 0;
    tick(CLOSE_HOLD_DEF + 1);
    chk("sim_both_idle", {32'(dut.u_entry.state), 32'(dut.u_exit.state)} == 64'd0, 1);

    // Reset while the exit gate is open
    exit_arrive = 1; exit_is_uni = 1;
    tick();
    chk("rst_exit_open", exit_gate_open, 1);
    exit_pass = 1;
    #2 reset = 1'b0;
    #1;
    chk("rst_gate_drops_now", exit_gate_open, 0);
    tick();
    chk("rst_no_strobe", car_exited, 0);
    exit_pass = 0; exit_arrive = 0;
    reset = 1'b1;
    tick();
    chk("rst_exit_idle", 32'(dut.u_exit.state), 32'(IDLE));
    chk("rst_still_no_strobe", car_exited, 0);
    tick(2);

    // Every queued strobe must have been seen
    chk("ent_queue_drained", exp_ent_q.size(), 0);
    chk("ext_queue_drained", exp_ext_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
